// File: rtl/decode_issue.sv
// Decode/issue/write-back front end: one instruction in flight, fixed 4-cycle occupancy.
// Optional DIV_ZERO_TRAP_EN suppresses write-back of divide-by-zero and raises sticky div_zero_err.
module decode_issue #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [7:0]        instr,
    output logic              instr_ready,
    input  logic              ld_en,
    input  logic [1:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [1:0]        op,
    output logic [DATA_W-1:0] src1_value,
    output logic [DATA_W-1:0] src2_value,
    input  logic [DATA_W-1:0] result,
    output logic              wb_valid,
    output logic [1:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
`ifdef DIV_ZERO_TRAP_EN
    output logic              div_zero_err,
`endif
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned OP_W  = 2;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [7:0]        instr_q;
    logic [DATA_W-1:0] regs [NREGS];
    logic              trap_q;

    logic [OP_W-1:0]  f_op;
    logic [IDX_W-1:0] f_rd;
    logic [IDX_W-1:0] f_rs1;
    logic [IDX_W-1:0] f_rs2;
    logic             accept;

    assign f_op  = instr_q[7:6];
    assign f_rd  = instr_q[5:4];
    assign f_rs1 = instr_q[3:2];
    assign f_rs2 = instr_q[1:0];

    assign instr_ready = (state_q == IDLE);
    assign accept      = instr_ready && instr_valid;
    assign dbg_data    = regs[dbg_addr];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_valid) state_d = ISSUE;
            ISSUE:   state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Instruction latch, operand issue, trap detection and write-back
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q    <= '0;
            op         <= '0;
            src1_value <= '0;
            src2_value <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            trap_q     <= 1'b0;
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
        end else begin
            wb_valid <= 1'b0;
            if (accept) instr_q <= instr;
            if (state_q == IDLE && ld_en) regs[ld_addr] <= ld_data;
            if (state_q == ISSUE) begin
                op         <= f_op;
                src1_value <= regs[f_rs1];
                src2_value <= regs[f_rs2];
`ifdef DIV_ZERO_TRAP_EN
                trap_q     <= (f_op == 2'b11) && (regs[f_rs2] == '0);
`else
                trap_q     <= 1'b0;
`endif
            end
            if (state_q == WB && !trap_q) begin
                regs[f_rd] <= result;
                wb_valid   <= 1'b1;
                wb_rd      <= f_rd;
                wb_data    <= result;
            end
        end
    end

`ifdef DIV_ZERO_TRAP_EN
    // Sticky divide-by-zero flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    div_zero_err <= 1'b0;
        else if (state_q == WB && trap_q) div_zero_err <= 1'b1;
    end
`endif

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
Front end of the first CPU. It accepts 8-bit instruction words over a valid/ready handshake and decodes them. It reads operands from an internal register file and drives op/src1_value/src2_value into the execute stage. It then captures execute's registered result one cycle later and writes it back to the destination register. Non-pipelined: one instruction in flight, fixed 4-cycle occupancy.

Parameters:
DATA_W, 8, register and operand width (matches execute datapath)
NREGS, 4, register file depth; register index is 2 bits, fixed by the instruction format

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
instr_valid  input  1  instruction word offered
instr  input  8  [7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2
instr_ready  output  1  high only in IDLE state (decoded from state register)
ld_en  input  1  external register preload strobe
ld_addr  input  2  preload register index
ld_data  input  DATA_W  preload value
op  output  2  to execute: 00 add, 01 sub, 10 mul, 11 div
src1_value  output  DATA_W  to execute: regfile[rs1]
src2_value  output  DATA_W  to execute: regfile[rs2]
result  input  DATA_W  from execute; registered there, one clock after op/src change
wb_valid  output  1  one-cycle pulse: write-back performed
wb_rd  output  2  register written
wb_data  output  DATA_W  value written
dbg_addr  input  2  debug read index
dbg_data  output  DATA_W  combinational regfile[dbg_addr]

Behaviour:
- Reset is asynchronous and active-low, with one clock. On reset assertion:
  - state goes to IDLE.
  - all registers, op, src1_value, src2_value, wb_rd and wb_data go to 0.
  - wb_valid goes to 0.
  - any in-flight instruction is abandoned with no register write.
- FSM: IDLE -> ISSUE -> EXEC -> WB -> IDLE.
- IDLE:
  - instr_ready=1.
  - instr_valid at edge N: latch instr; next state ISSUE.
  - ld_en at an edge: regfile[ld_addr]<=ld_data.
  - ld_en is honoured only in IDLE and ignored in every other state.
  - ld_en and a handshake at the same edge: both occur, and the preload is visible to the accepted instruction.
- ISSUE (edge N+1): op, src1_value and src2_value are registered from the latched instruction and the current regfile contents. Next state EXEC.
- EXEC (edge N+2): no action while execute registers the result. Next state WB.
- WB (edge N+3):
  - regfile[rd]<=result.
  - wb_valid<=1, wb_rd<=rd, wb_data<=result.
  - next state IDLE.
- wb_valid is high for exactly one cycle after edge N+3.
- Earliest next accept is edge N+4, so throughput is 1 instruction per 4 cycles.
- op/src outputs hold their last issued values until the next ISSUE.
- rd equal to rs1 or rs2: operands use the old value, and the write happens at WB.
- Arithmetic is entirely in execute. Write-back takes result as-is (DATA_W bits, already truncated or wrapped by execute).
- dbg_data reflects a write-back or preload from the cycle after the write edge.

Optional Feature:
DIV_ZERO_TRAP_EN
- Defined:
  - adds output div_zero_err (1 bit, sticky, cleared only by reset).
  - in ISSUE, if op==11 and regfile[rs2]==0, set a trap flag; the instruction still follows the ISSUE -> EXEC -> WB timing.
  - in WB with the trap flag set: no regfile write, wb_valid stays 0, div_zero_err<=1.
- Undefined: port absent; divide-by-zero writes back whatever execute produces.

Test Plan:
- Reset low mid-WB with regs preloaded -> after release all dbg reads 0, instr_ready=1, wb_valid=0, op=0.
- Preload r1=7, r2=5 via ld_en; issue instr 0x16 (add r1,r1,r2) at edge N -> op=00, src1=7, src2=5 after N+1; wb_valid pulse after N+3 with wb_rd=1, wb_data=12; dbg r1=12.
- r1=3, r2=5; sub r0,r1,r2 (0x46) -> wb_data=0xFE (wraps); mul r3,r1,r2 (0xB6) with r1=20, r2=20 -> wb_data=0x90.
- Hold instr_valid high continuously with two instructions -> instr_ready high only in IDLE, accepts 4 cycles apart; second instruction reads the first one's write-back.
- ld_en in ISSUE/EXEC/WB -> ignored; ld_en and handshake at the same IDLE edge -> instruction uses the preloaded value.
- DIV_ZERO_TRAP_EN: r2=0, div r3,r1,r2 (0xF6) -> no wb_valid, r3 unchanged, div_zero_err=1 until reset; without the macro -> wb_valid pulses with execute's output.
